serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 137 +++++++++++++
 tb/tb_serial_adder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-add cell per clock, LSB first, valid/ready on both sides.
// Define SERIAL_ADDER_OVF_EN to add the registered two's-complement overflow output Ovf.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             Ovf
`endif
);

    // state | meaning
    // IDLE  | waiting for operands, in_ready high
    // SHIFT | one bit per clock through the full-add cell
    // DONE  | result presented, waiting for out_ready
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_c;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-2:0]   r_sum_sh;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic               r_ovf;
`endif

    logic               w_accept;
    logic               w_last;
    logic               w_s;
    logic               w_c_nxt;
    logic [WIDTH-1:0]   w_sum_full;

    assign w_accept   = in_valid && in_ready;
    assign w_last     = (r_state == SHIFT) && (r_cnt == LAST_BIT);
    assign w_s        = r_a[0] ^ r_b[0] ^ r_c;
    assign w_c_nxt    = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));
    // The final bit completes the word; earlier bits sit below it in the shift register.
    assign w_sum_full = {w_s, r_sum_sh};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (r_cnt == LAST_BIT) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            r_sum_sh <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a   <= A;
            r_b   <= B;
            r_c   <= Cin;
            r_cnt <= '0;
        end else if (r_state == SHIFT) begin
            r_a      <= {1'b0, r_a[WIDTH-1:1]};
            r_b      <= {1'b0, r_b[WIDTH-1:1]};
            r_c      <= w_c_nxt;
            r_sum_sh <= w_sum_full[WIDTH-1:1];
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_sum  <= w_sum_full;
                r_cout <= w_c_nxt;
`ifdef SERIAL_ADDER_OVF_EN
                // r_c is the carry into the MSB on this final step.
                r_ovf  <= r_c ^ w_c_nxt;
`endif
            end
        end
    end

    assign Sum  = r_sum;
    assign Cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    assign Ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8), one task per scenario.
`timescale 1ns/1ps
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .Cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (sum),
        .Cout      (cout),
        .busy      (busy)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .Ovf       (ovf)
`endif
    );

    // Presents one operand set, waits for out_valid; reports latency and busy cycles.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, output int lat, output int busy_cnt);
        @(negedge clk);
        in_valid = 1'b1;
        a = ta;
        b = tb;
        cin = tc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!out_valid && lat < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_op();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b1;
        a = 8'h33;
        b = 8'h44;
        cin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (sum !== 8'h00 || cout !== 1'b0) begin
            bad++;
            $display("FAIL reset_sum: got sum=%h cout=%b want 00/0", sum, cout);
        end
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got out_valid=%b busy=%b in_ready=%b want 0/0/0",
                     out_valid, busy, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got in_ready=%b busy=%b out_valid=%b want 1/0/0",
                     in_ready, busy, out_valid);
        end
    endtask

    task automatic test_basic();
        int lat, bc;
        do_op(8'h0F, 8'h01, 1'b0, lat, bc);
        total++;
        if (lat !== W || bc !== W) begin
            bad++;
            $display("FAIL basic_latency: got lat=%0d busy_cycles=%0d want %0d/%0d", lat, bc, W, W);
        end
        total++;
        if (out_valid !== 1'b1 || sum !== 8'h10 || cout !== 1'b0) begin
            bad++;
            $display("FAIL basic_result: got v=%b sum=%h cout=%b want 1/10/0", out_valid, sum, cout);
        end
        release_op();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 8'h10) begin
            bad++;
            $display("FAIL basic_release: got v=%b in_ready=%b sum=%h want 0/1/10", out_valid, in_ready, sum);
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] va [4] = '{8'hFF, 8'hFF, 8'hAA, 8'h80};
        logic [W-1:0] vb [4] = '{8'h00, 8'hFF, 8'h55, 8'h80};
        logic         vc [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [W-1:0] es [4] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
        logic         ec [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        int lat, bc;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], vc[i], lat, bc);
            total++;
            if (out_valid !== 1'b1 || sum !== es[i] || cout !== ec[i]) begin
                bad++;
                $display("FAIL wrap_%0d: got v=%b sum=%h cout=%b want 1/%h/%b",
                         i, out_valid, sum, cout, es[i], ec[i]);
            end
            release_op();
        end
    endtask

    task automatic test_backpressure();
        int lat, bc;
        int errs;
        do_op(8'h12, 8'h34, 1'b0, lat, bc);
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = 8'(i * 17);
            b = 8'(8'hF0 - i);
            cin = 1'b1;
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || sum !== 8'h46 || cout !== 1'b0 || in_ready !== 1'b0) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL bp_hold: got %0d bad cycles (last v=%b sum=%h cout=%b rdy=%b) want 0",
                     errs, out_valid, sum, cout, in_ready);
        end
        @(negedge clk);
        a = 8'h01;
        b = 8'h02;
        cin = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_no_b2b: got v=%b busy=%b rdy=%b want 0/0/1", out_valid, busy, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b1 || sum !== 8'h46) begin
            bad++;
            $display("FAIL bp_accept_next: got busy=%b sum=%h want 1/46", busy, sum);
        end
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        total++;
        if (lat !== W || sum !== 8'h03 || cout !== 1'b0) begin
            bad++;
            $display("FAIL bp_second: got lat=%0d sum=%h cout=%b want %0d/03/0", lat, sum, cout, W);
        end
        release_op();
    endtask

    task automatic test_mid_reset();
        int seen;
        @(negedge clk);
        in_valid = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        cin = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            bad++;
            $display("FAIL midrst_state: got busy=%b v=%b sum=%h cout=%b want 0/0/00/0",
                     busy, out_valid, sum, cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_ready: got in_ready=%b want 1", in_ready);
        end
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL midrst_quiet: got %0d active cycles want 0", seen);
        end
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_ovf();
        logic [W-1:0] va [3] = '{8'h7F, 8'h80, 8'hFF};
        logic [W-1:0] vb [3] = '{8'h01, 8'h80, 8'h01};
        logic [W-1:0] es [3] = '{8'h80, 8'h00, 8'h00};
        logic         ec [3] = '{1'b0, 1'b1, 1'b1};
        logic         eo [3] = '{1'b1, 1'b1, 1'b0};
        int lat, bc;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], 1'b0, lat, bc);
            total++;
            if (sum !== es[i] || cout !== ec[i] || ovf !== eo[i]) begin
                bad++;
                $display("FAIL ovf_%0d: got sum=%h cout=%b ovf=%b want %h/%b/%b",
                         i, sum, cout, ovf, es[i], ec[i], eo[i]);
            end
            release_op();
        end
    endtask
`endif

    initial begin
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_mid_reset();
`ifdef SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
